// File: rtl/wb_dcache_flush_seq.sv
// ---------------------------------------------------------------------------
// wb_dcache_flush_seq
//
// Flush sequencer for the write-back data cache (fence / fence.i). Walks every
// set/way entry of the tag/status array in order (set-major, way-minor). Each
// entry is read, dirty lines are handed to the writeback unit, and the line
// is then invalidated. The sequencer owns the tag and writeback ports while
// busy_o is high.
//
// Optional feature (macro WB_DCACHE_CLEAN_ONLY_EN):
//   adds clean_only_i (latched at flush start) and tag_keep_valid_o. In
//   clean-only mode clean lines are left untouched and dirty lines are
//   written back and then rewritten as valid/clean (tag_keep_valid_o=1).
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   flush_i / flush_ack_o     flush request (sampled in IDLE) / 1-cycle done
//   busy_o                    high in every state except IDLE
//   tag_req_o, tag_we_o,
//   tag_set_o, tag_way_o      tag-array access (we=1: invalidate write)
//   tag_gnt_i                 tag-array grant, access happens in grant cycle
//   tag_valid_i, tag_dirty_i,
//   tag_i                     read data, valid one cycle after a read grant
//   wb_req_o, wb_addr_o,
//   wb_way_o                  writeback request for a dirty line
//   wb_gnt_i, wb_done_i       writeback accepted / writeback finished
//   clean_only_i              (WB_DCACHE_CLEAN_ONLY_EN) keep lines valid
//   tag_keep_valid_o          (WB_DCACHE_CLEAN_ONLY_EN) write keeps valid=1
// ---------------------------------------------------------------------------
module wb_dcache_flush_seq #(
    parameter  int unsigned NUM_SETS      = 256,
    parameter  int unsigned NUM_WAYS      = 8,
    parameter  int unsigned LINE_OFFSET_W = 4,
    parameter  int unsigned PLEN          = 56,
    localparam int unsigned SET_W         = $clog2(NUM_SETS),
    localparam int unsigned WAY_W         = $clog2(NUM_WAYS),
    localparam int unsigned TAG_W         = PLEN - SET_W - LINE_OFFSET_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    output logic             flush_ack_o,
    output logic             busy_o,
    output logic             tag_req_o,
    output logic             tag_we_o,
    output logic [SET_W-1:0] tag_set_o,
    output logic [WAY_W-1:0] tag_way_o,
    input  logic             tag_gnt_i,
    input  logic             tag_valid_i,
    input  logic             tag_dirty_i,
    input  logic [TAG_W-1:0] tag_i,
`ifdef WB_DCACHE_CLEAN_ONLY_EN
    input  logic             clean_only_i,
    output logic             tag_keep_valid_o,
`endif
    output logic             wb_req_o,
    output logic [PLEN-1:0]  wb_addr_o,
    output logic [WAY_W-1:0] wb_way_o,
    input  logic             wb_gnt_i,
    input  logic             wb_done_i
);

    typedef enum logic [2:0] {
        IDLE, READ, CHECK, WB_REQ, WB_WAIT, INVAL, DONE
    } state_e;

    state_e           state_q, state_d;
    logic [SET_W-1:0] set_q, set_d;
    logic [WAY_W-1:0] way_q, way_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             adv;
    logic             last_entry;

    logic             busy_q, ack_q, tag_req_q, tag_we_q, wb_req_q;
`ifdef WB_DCACHE_CLEAN_ONLY_EN
    logic             co_q, co_d;
    logic             keep_q;
`endif

    // Sizes are powers of two, so the last set/way index is all ones.
    assign last_entry = (&set_q) && (&way_q);

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        way_d   = way_q;
        tag_d   = tag_q;
        adv     = 1'b0;
`ifdef WB_DCACHE_CLEAN_ONLY_EN
        co_d    = co_q;
`endif
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = READ;
                    set_d   = '0;
                    way_d   = '0;
`ifdef WB_DCACHE_CLEAN_ONLY_EN
                    co_d    = clean_only_i;
`endif
                end
            end
            READ: begin
                if (tag_gnt_i) state_d = CHECK;
            end
            CHECK: begin
                if (!tag_valid_i) begin
                    adv = 1'b1;
                end else if (tag_dirty_i) begin
                    tag_d   = tag_i;
                    state_d = WB_REQ;
                end else begin
`ifdef WB_DCACHE_CLEAN_ONLY_EN
                    if (co_q) adv = 1'b1;
                    else      state_d = INVAL;
`else
                    state_d = INVAL;
`endif
                end
            end
            WB_REQ: begin
                if (wb_gnt_i) state_d = wb_done_i ? INVAL : WB_WAIT;
            end
            WB_WAIT: begin
                if (wb_done_i) state_d = INVAL;
            end
            INVAL: begin
                if (tag_gnt_i) adv = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Step to the next entry; after the last entry both counters wrap to 0.
        if (adv) begin
            state_d = last_entry ? DONE : READ;
            if (&way_q) begin
                way_d = '0;
                set_d = set_q + 1'b1;
            end else begin
                way_d = way_q + 1'b1;
            end
        end
    end

    // Output flops are loaded from the next state so every output is a
    // register that lines up with the state it belongs to.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            set_q     <= '0;
            way_q     <= '0;
            tag_q     <= '0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            tag_req_q <= 1'b0;
            tag_we_q  <= 1'b0;
            wb_req_q  <= 1'b0;
`ifdef WB_DCACHE_CLEAN_ONLY_EN
            co_q      <= 1'b0;
            keep_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            set_q     <= set_d;
            way_q     <= way_d;
            tag_q     <= tag_d;
            busy_q    <= (state_d != IDLE);
            ack_q     <= (state_d == DONE);
            tag_req_q <= (state_d == READ) || (state_d == INVAL);
            tag_we_q  <= (state_d == INVAL);
            wb_req_q  <= (state_d == WB_REQ);
`ifdef WB_DCACHE_CLEAN_ONLY_EN
            co_q      <= co_d;
            keep_q    <= (state_d == INVAL) && co_d;
`endif
        end
    end

    assign busy_o      = busy_q;
    assign flush_ack_o = ack_q;
    assign tag_req_o   = tag_req_q;
    assign tag_we_o    = tag_we_q;
    assign tag_set_o   = set_q;
    assign tag_way_o   = way_q;
    assign wb_req_o    = wb_req_q;
    assign wb_addr_o   = {tag_q, set_q, {LINE_OFFSET_W{1'b0}}};
    assign wb_way_o    = way_q;
`ifdef WB_DCACHE_CLEAN_ONLY_EN
    assign tag_keep_valid_o = keep_q;
`endif

endmodule
